// File: rtl/arith_mult_solinas_karatsuba_pipe_if.sv
// rtl/arith_mult_solinas_karatsuba_pipe_if.sv - operand/result bundle for the Solinas modular multiplier
// Ports (slave = multiplier side):
//   a, b     : operands, any MOD_W-bit value
//   m_avail  : operand valid
//   m_side   : side-band tag travelling with the operation
//   z        : canonical a*b mod p
//   z_avail  : result valid
//   z_side   : tag of the operation producing z
interface arith_mult_solinas_karatsuba_pipe_if #(
  parameter int MOD_W  = 64,
  parameter int SIDE_W = 1
);
  logic [MOD_W-1:0]  a;
  logic [MOD_W-1:0]  b;
  logic              m_avail;
  logic [SIDE_W-1:0] m_side;
  logic [MOD_W-1:0]  z;
  logic              z_avail;
  logic [SIDE_W-1:0] z_side;

  modport master (output a, b, m_avail, m_side, input z, z_avail, z_side);
  modport slave  (input a, b, m_avail, m_side, output z, z_avail, z_side);
endinterface

// File: rtl/arith_mult_solinas_karatsuba_pipe.sv
// rtl/arith_mult_solinas_karatsuba_pipe.sv - pipelined a*b mod (2^MOD_W - 2^(MOD_W/2) + 1)
// Ports:
//   clk     : clock
//   s_rst_n : asynchronous active-low reset, clears every stage
//   en      : pipeline enable, 0 freezes every register
//   bus     : slave modport carrying a/b/m_avail/m_side in and z/z_avail/z_side out
// Stages: [input reg] -> pre-add -> MULT_PIPE x sub-multiply -> combine -> fold -> correct
module arith_mult_solinas_karatsuba_pipe #(
  parameter int MOD_W     = 64,
  parameter int IN_PIPE   = 1,
  parameter int MULT_PIPE = 2,
  parameter int SIDE_W    = 1
) (
  input  logic clk,
  input  logic s_rst_n,
  input  logic en,
  arith_mult_solinas_karatsuba_pipe_if.slave bus
);
  localparam int LATENCY = IN_PIPE + MULT_PIPE + 4;
  localparam int H       = MOD_W / 2;
  localparam int RW      = MOD_W + 3;
  // p = 2^MOD_W - 2^H + 1, and 2p, both at fold width
  localparam logic [RW-1:0] P_EXT  = {3'b000, {H{1'b1}}, {(H-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] P2_EXT = {P_EXT[RW-2:0], 1'b0};

  if (!(MOD_W == 32 || MOD_W == 64)) begin : g_bad_mod_w
    $error("arith_mult_solinas_karatsuba_pipe: MOD_W must be 32 or 64");
  end
  if (IN_PIPE < 0 || IN_PIPE > 1) begin : g_bad_in_pipe
    $error("arith_mult_solinas_karatsuba_pipe: IN_PIPE must be 0 or 1");
  end
  if (MULT_PIPE < 1 || MULT_PIPE > 4) begin : g_bad_mult_pipe
    $error("arith_mult_solinas_karatsuba_pipe: MULT_PIPE must be 1..4");
  end
  if (SIDE_W < 1) begin : g_bad_side_w
    $error("arith_mult_solinas_karatsuba_pipe: SIDE_W must be >= 1");
  end

  // Bubble slots carry zero data and zero tag, so their z is deterministically 0.
  logic [MOD_W-1:0]  w_a_gate;
  logic [MOD_W-1:0]  w_b_gate;
  logic [SIDE_W-1:0] w_side_gate;
  assign w_a_gate    = bus.m_avail ? bus.a : '0;
  assign w_b_gate    = bus.m_avail ? bus.b : '0;
  assign w_side_gate = bus.m_avail ? bus.m_side : '0;

  logic [MOD_W-1:0] w_a_in;
  logic [MOD_W-1:0] w_b_in;

  if (IN_PIPE == 1) begin : g_in_reg
    logic [MOD_W-1:0] r_a_in;
    logic [MOD_W-1:0] r_b_in;
    always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
        r_a_in <= '0;
        r_b_in <= '0;
      end else if (en) begin
        r_a_in <= w_a_gate;
        r_b_in <= w_b_gate;
      end
    end
    assign w_a_in = r_a_in;
    assign w_b_in = r_b_in;
  end else begin : g_in_wire
    assign w_a_in = w_a_gate;
    assign w_b_in = w_b_gate;
  end

  // Pre-add: split into halves and form the Karatsuba middle-term operands.
  logic [H-1:0] r_al, r_ah, r_bl, r_bh;
  logic [H:0]   r_as, r_bs;
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_al <= '0;
      r_ah <= '0;
      r_bl <= '0;
      r_bh <= '0;
      r_as <= '0;
      r_bs <= '0;
    end else if (en) begin
      r_al <= w_a_in[H-1:0];
      r_ah <= w_a_in[MOD_W-1:H];
      r_bl <= w_b_in[H-1:0];
      r_bh <= w_b_in[MOD_W-1:H];
      r_as <= {1'b0, w_a_in[MOD_W-1:H]} + {1'b0, w_a_in[H-1:0]};
      r_bs <= {1'b0, w_b_in[MOD_W-1:H]} + {1'b0, w_b_in[H-1:0]};
    end
  end

  // Sub-multipliers: combinational product followed by MULT_PIPE registers.
  logic [2*H-1:0] w_pl, w_ph;
  logic [2*H+1:0] w_pm;
  assign w_pl = {{H{1'b0}}, r_al} * {{H{1'b0}}, r_bl};
  assign w_ph = {{H{1'b0}}, r_ah} * {{H{1'b0}}, r_bh};
  assign w_pm = {{(H+1){1'b0}}, r_as} * {{(H+1){1'b0}}, r_bs};

  logic [2*H-1:0] r_pl [MULT_PIPE];
  logic [2*H-1:0] r_ph [MULT_PIPE];
  logic [2*H+1:0] r_pm [MULT_PIPE];
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int k = 0; k < MULT_PIPE; k++) begin
        r_pl[k] <= '0;
        r_ph[k] <= '0;
        r_pm[k] <= '0;
      end
    end else if (en) begin
      r_pl[0] <= w_pl;
      r_ph[0] <= w_ph;
      r_pm[0] <= w_pm;
      for (int k = 1; k < MULT_PIPE; k++) begin
        r_pl[k] <= r_pl[k-1];
        r_ph[k] <= r_ph[k-1];
        r_pm[k] <= r_pm[k-1];
      end
    end
  end

  // Combine: middle term pm-ph-pl = ah*bl + al*bh is never negative.
  logic [2*H+1:0]     w_mid;
  logic [2*MOD_W-1:0] w_x;
  logic [2*MOD_W-1:0] r_x;
  assign w_mid = r_pm[MULT_PIPE-1] - {2'b00, r_ph[MULT_PIPE-1]} - {2'b00, r_pl[MULT_PIPE-1]};
  assign w_x   = {r_ph[MULT_PIPE-1], {MOD_W{1'b0}}}
               + {{(H-2){1'b0}}, w_mid, {H{1'b0}}}
               + {{MOD_W{1'b0}}, r_pl[MULT_PIPE-1]};
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n)  r_x <= '0;
    else if (en)   r_x <= w_x;
  end

  // Fold: x3*2^3H + x2*2^2H + x1*2^H + x0 == (x1+x2)*2^H + x0 - x2 - x3 (mod p).
  // Result lies in (-2^(H+1), 3p), kept as two's complement at RW bits.
  logic [H-1:0]  w_x0, w_x1, w_x2, w_x3;
  logic [H:0]    w_t;
  logic [RW-1:0] w_pos, w_neg, w_r;
  logic [RW-1:0] r_r;
  assign {w_x3, w_x2, w_x1, w_x0} = r_x;
  assign w_t   = {1'b0, w_x1} + {1'b0, w_x2};
  assign w_pos = {2'b00, w_t, w_x0};
  assign w_neg = {{(RW-H){1'b0}}, w_x2} + {{(RW-H){1'b0}}, w_x3};
  assign w_r   = w_pos - w_neg;
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n)  r_r <= '0;
    else if (en)   r_r <= w_r;
  end

  // Correct: pick r+p, r, r-p or r-2p; only the low MOD_W bits of the winner matter.
  logic             w_neg_r, w_ge_p, w_ge_2p;
  logic [MOD_W-1:0] w_z;
  logic [MOD_W-1:0] r_z;
  assign w_neg_r = r_r[RW-1];
  assign w_ge_p  = (r_r >= P_EXT);
  assign w_ge_2p = (r_r >= P2_EXT);
  always_comb begin
    w_z = r_r[MOD_W-1:0];
    if (w_neg_r)       w_z = r_r[MOD_W-1:0] + P_EXT[MOD_W-1:0];
    else if (w_ge_2p)  w_z = r_r[MOD_W-1:0] - P2_EXT[MOD_W-1:0];
    else if (w_ge_p)   w_z = r_r[MOD_W-1:0] - P_EXT[MOD_W-1:0];
  end
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n)  r_z <= '0;
    else if (en)   r_z <= w_z;
  end

  // Valid/tag delay line, one entry per data stage.
  logic              r_vld [LATENCY];
  logic [SIDE_W-1:0] r_sd  [LATENCY];
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_vld[k] <= 1'b0;
        r_sd[k]  <= '0;
      end
    end else if (en) begin
      r_vld[0] <= bus.m_avail;
      r_sd[0]  <= w_side_gate;
      for (int k = 1; k < LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_sd[k]  <= r_sd[k-1];
      end
    end
  end

  assign bus.z       = r_z;
  assign bus.z_avail = r_vld[LATENCY-1];
  assign bus.z_side  = r_sd[LATENCY-1];
endmodule

// File: tb/tb_arith_mult_solinas_karatsuba_pipe.sv
// tb/tb_arith_mult_solinas_karatsuba_pipe.sv - self-checking bench for the Solinas modular multiplier
module tb_arith_mult_solinas_karatsuba_pipe;
  localparam int LAT64 = 1 + 2 + 4;
  localparam int LAT32 = 0 + 1 + 4;
  localparam logic [63:0] P64 = 64'hFFFF_FFFF_0000_0001;
  localparam logic [31:0] P32 = 32'hFFFF_0001;

  typedef struct packed {
    logic        avail;
    logic [15:0] side;
    logic [63:0] z;
  } slot_t;

  logic clk = 1'b0;
  logic s_rst_n = 1'b0;
  logic en = 1'b1;
  always #5 clk = ~clk;

  arith_mult_solinas_karatsuba_pipe_if #(.MOD_W(64), .SIDE_W(16)) bus64 ();
  arith_mult_solinas_karatsuba_pipe_if #(.MOD_W(32), .SIDE_W(8))  bus32 ();

  arith_mult_solinas_karatsuba_pipe #(.MOD_W(64), .IN_PIPE(1), .MULT_PIPE(2), .SIDE_W(16)) dut64 (
    .clk(clk), .s_rst_n(s_rst_n), .en(en), .bus(bus64));
  arith_mult_solinas_karatsuba_pipe #(.MOD_W(32), .IN_PIPE(0), .MULT_PIPE(1), .SIDE_W(8)) dut32 (
    .clk(clk), .s_rst_n(s_rst_n), .en(en), .bus(bus32));

  // Reference: each DUT is a fixed-length delay line of results advancing on enabled edges.
  slot_t q64[$];
  slot_t q32[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_in64  = 0;
  int n_out64 = 0;

  function automatic logic [63:0] ref64(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] prod;
    prod = {64'd0, a} * {64'd0, b};
    return 64'(prod % {64'd0, P64});
  endfunction

  function automatic logic [31:0] ref32(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    return 32'(prod % {32'd0, P32});
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return P64;
      3: return P64 - 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return P32;
      3: return P32 - 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    q64.delete();
    q32.delete();
    for (int i = 0; i < LAT64; i++) q64.push_back('0);
    for (int i = 0; i < LAT32; i++) q32.push_back('0);
  endtask

  task automatic check(input string tag, input logic [80:0] obs, input logic [80:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [80:0] obs64();
    return {bus64.z_avail, bus64.z_side, bus64.z};
  endfunction

  function automatic logic [80:0] obs32();
    return {bus32.z_avail, 8'h00, bus32.z_side, 32'h0, bus32.z};
  endfunction

  // One clock: advance the reference on the edge, compare both DUTs 1 time unit later.
  task automatic tick();
    slot_t s;
    logic  adv;
    @(posedge clk);
    adv = s_rst_n && en;
    if (!s_rst_n) begin
      model_reset();
    end else if (en) begin
      s.avail = bus64.m_avail;
      s.side  = bus64.m_avail ? bus64.m_side : 16'h0;
      s.z     = bus64.m_avail ? ref64(bus64.a, bus64.b) : 64'h0;
      void'(q64.pop_front());
      q64.push_back(s);
      if (bus64.m_avail) n_in64++;
      s.avail = bus32.m_avail;
      s.side  = bus32.m_avail ? {8'h00, bus32.m_side} : 16'h0;
      s.z     = bus32.m_avail ? {32'h0, ref32(bus32.a, bus32.b)} : 64'h0;
      void'(q32.pop_front());
      q32.push_back(s);
    end
    #1;
    check("pipe64", obs64(), q64[0]);
    check("pipe32", obs32(), q32[0]);
    if (adv && bus64.z_avail) n_out64++;
  endtask

  task automatic dir64(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [15:0] side, input logic [63:0] exp);
    bus64.a = a; bus64.b = b; bus64.m_avail = 1'b1; bus64.m_side = side;
    bus32.m_avail = 1'b0;
    tick();
    bus64.m_avail = 1'b0; bus64.a = rnd64(); bus64.b = rnd64();
    repeat (LAT64 - 1) tick();
    check(tag, obs64(), {1'b1, side, exp});
  endtask

  task automatic dir32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] side, input logic [31:0] exp);
    bus32.a = a; bus32.b = b; bus32.m_avail = 1'b1; bus32.m_side = side;
    bus64.m_avail = 1'b0;
    tick();
    bus32.m_avail = 1'b0; bus32.a = rnd32(); bus32.b = rnd32();
    repeat (LAT32 - 1) tick();
    check(tag, obs32(), {1'b1, 8'h00, side, 32'h0, exp});
  endtask

  task automatic rand_inputs(input int idx, input int avail_pct);
    bus64.a = rnd64(); bus64.b = rnd64();
    bus64.m_avail = ($urandom_range(0, 99) < avail_pct);
    bus64.m_side  = 16'(idx);
    bus32.a = rnd32(); bus32.b = rnd32();
    bus32.m_avail = ($urandom_range(0, 99) < avail_pct);
    bus32.m_side  = 8'(idx);
  endtask

  initial begin
    bus64.a = '0; bus64.b = '0; bus64.m_avail = 1'b0; bus64.m_side = '0;
    bus32.a = '0; bus32.b = '0; bus32.m_avail = 1'b0; bus32.m_side = '0;
    model_reset();

    // Reset state, during and right after reset
    #2;
    check("reset64", obs64(), '0);
    check("reset32", obs32(), '0);
    tick();
    tick();
    #4 s_rst_n = 1'b1;
    tick();
    check("post_reset64", obs64(), '0);

    // Directed corner values
    dir64("p_minus_1_sq",  P64 - 64'd1, P64 - 64'd1, 16'h1111, 64'd1);
    dir64("two32_sq",      64'h1_0000_0000, 64'h1_0000_0000, 16'h2222, 64'hFFFF_FFFF);
    dir64("two63_x2",      64'h8000_0000_0000_0000, 64'd2, 16'h3333, 64'hFFFF_FFFF);
    dir64("all_ones_x1",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 16'h4444, 64'hFFFF_FFFE);
    dir64("a_eq_p",        P64, 64'h1234_5678_9ABC_DEF0, 16'h5555, 64'd0);
    dir64("a_zero",        64'd0, 64'hDEAD_BEEF_CAFE_F00D, 16'h6666, 64'd0);
    dir64("b_zero",        64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 16'h7777, 64'd0);
    dir32("w32_two16_sq",  32'h0001_0000, 32'h0001_0000, 8'h81, 32'h0000_FFFF);
    dir32("w32_pm1_sq",    32'hFFFF_0000, 32'hFFFF_0000, 8'h82, 32'd1);
    dir32("w32_a_eq_p",    P32, 32'h1357_9BDF, 8'h83, 32'd0);
    dir32("w32_all_ones",  32'hFFFF_FFFF, 32'd1, 8'h84, 32'h0000_FFFE);

    // Back-to-back random stream with bubbles, then random enable gaps
    n_in64 = 0;
    n_out64 = 0;
    for (int i = 0; i < 1000; i++) begin
      rand_inputs(i, 75);
      tick();
    end
    for (int i = 0; i < 400; i++) begin
      rand_inputs(1000 + i, 80);
      en = ($urandom_range(0, 9) >= 3);
      tick();
    end
    en = 1'b1;
    bus64.m_avail = 1'b0;
    bus32.m_avail = 1'b0;
    repeat (LAT64) tick();
    check("avail_count", 81'(n_out64), 81'(n_in64));

    // Asynchronous reset with five operations in flight
    for (int i = 0; i < 5; i++) begin
      rand_inputs(2000 + i, 100);
      tick();
    end
    bus64.m_avail = 1'b0;
    bus32.m_avail = 1'b0;
    #2 s_rst_n = 1'b0;
    #1;
    check("async_rst64", obs64(), '0);
    check("async_rst32", obs32(), '0);
    model_reset();
    tick();
    #3 s_rst_n = 1'b1;
    repeat (LAT64) tick();
    dir64("after_reset", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 16'hBEEF,
          ref64(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arith_mult_solinas_karatsuba_pipe.md
Name: arith_mult_solinas_karatsuba_pipe

Overview:
- Fully pipelined modular multiplier: z = a*b mod p, with p = 2^MOD_W - 2^(MOD_W/2) + 1.
  - MOD_W=64 gives the Goldilocks prime; MOD_W=32 gives 2^32-2^16+1.
- Karatsuba product from three (MOD_W/2+1)-bit sub-products, then a two-stage Solinas folding reduction to the canonical range [0,p).
- Carries an avail/side-band pipe alongside the data, for use in NTT butterflies and the PBS modswitch path.
- Generalises the fixed 64-bit Goldilocks multiplier to parametrised width, input pipe and sub-multiplier depth, and adds a side-band channel and a pipeline enable.

Parameters:
- MOD_W, 64, modulus width; must be even and one of {32, 64}; elaboration error otherwise.
- IN_PIPE, 1, input register stage count; 0 or 1.
- MULT_PIPE, 2, pipeline depth of each sub-multiplier; 1 to 4.
- SIDE_W, 1, width of the side-band carried with each operation; ≥1.
- LATENCY, derived, IN_PIPE + MULT_PIPE + 4; exposed as a localparam for parents.

Ports:
- clk, in, 1, clock.
- s_rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, pipeline enable; 0 freezes every stage.
- a, in, MOD_W, operand A; any MOD_W-bit value.
- b, in, MOD_W, operand B; any MOD_W-bit value.
- m_avail, in, 1, operand valid.
- m_side, in, SIDE_W, side-band tag.
- z, out, MOD_W, a*b mod p, canonical.
- z_avail, out, 1, result valid.
- z_side, out, SIDE_W, tag of the operation producing z.

Behaviour:
- Reset (s_rst_n=0, asynchronous): all stage registers clear, including data and side-band. While in reset and immediately after release: z=0, z_avail=0, z_side=0.
- Reset asserted mid-operation: all in-flight operations are discarded; no result for them ever emerges.
- Pipeline stages, in order:
  - IN_PIPE: optional input register.
  - Pre-add, 1 cycle:
    - a = ah*2^H + al, b = bh*2^H + bl, with H = MOD_W/2.
    - as = ah+al, bs = bh+bl, each H+1 bits.
  - Sub-multiply, MULT_PIPE cycles: pl = al*bl, ph = ah*bh, pm = as*bs.
  - Combine, 1 cycle: x = ph*2^MOD_W + (pm-ph-pl)*2^H + pl, 2*MOD_W bits exact.
  - Fold, 1 cycle:
    - Split x into four H-bit limbs x3..x0.
    - Form r = (x1+x2)*2^H + x0 - x2 - x3, using 2^MOD_W ≡ 2^H-1 and 2^(3H) ≡ -1.
    - Hold r as a signed value of MOD_W+3 bits.
  - Correct, 1 cycle: add or subtract multiples of p (at most 3 candidates, selected in parallel) so that 0 ≤ z < p.
- Latency: with en held at 1, the operation sampled on cycle t appears on z/z_avail/z_side at cycle t+LATENCY. Default: 1+2+4 = 7.
- Throughput: one operation per cycle; no back-pressure; no ready signal.
- m_avail=0: the slot advances as a bubble and produces z_avail=0.
  - Data registers still load in bubble slots. Their z value is don't-care, but must be deterministic for a bench; the design clears them.
- en=0: every register, including avail and side, holds its value. Outputs stay stable. Inputs presented during en=0 are ignored. Latency counts only cycles with en=1.
- z_side reproduces m_side exactly, aligned with z_avail; z_side is 0 in bubble slots.
- Out-of-range operands (a or b ≥ p) are legal; the result is still canonical.
- Special values:
  - a=0 or b=0 gives z=0.
  - a=p gives z=0.
  - a=2^MOD_W-1 is valid input.
- No saturation flags, no overflow output.

Test Plan:
- MOD_W=64, a=b=p-1=0xFFFFFFFF00000000 → z=1 at cycle t+7, z_avail=1, z_side=m_side.
- MOD_W=64:
  - a=b=2^32 → z=0xFFFFFFFF (2^32-1).
  - a=2^63, b=2 → z=0xFFFFFFFF (2^64 ≡ 2^32-1).
  - a=0xFFFFFFFFFFFFFFFF, b=1 → z=0xFFFFFFFE.
- MOD_W=32, IN_PIPE=0, MULT_PIPE=1:
  - a=b=0x10000 → z=0xFFFF after 5 cycles.
  - a=b=0xFFFF0000 → z=1.
- 1000 back-to-back random pairs with random bubbles, m_side=index → every z matches a golden a*b mod p, in order, with correct tag; z_avail count equals m_avail count.
- en toggled randomly (30% low) during a stream → outputs frozen while en=0; results and order unchanged versus en=1; latency measured in enabled cycles.
- s_rst_n pulsed low asynchronously mid-cycle with 5 operations in flight → z_avail=0 and z=0 immediately; none of those 5 results appear; a new operation after release returns correct z after LATENCY.
